// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access in flight, registered request bus to the data RAM,
// load extension and a single response carrying an error code.
module load_store_unit #(
  parameter int unsigned MEM_TIMEOUT = 32'd16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_base_i,
  input  logic [31:0] req_offset_i,
  input  logic [31:0] req_store_data_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic [1:0]  resp_err_o,
  output logic [31:0] resp_addr_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_valid_o,
  output logic        mem_write_valid_o,
  output logic [31:0] mem_write_data_o,
  output logic [1:0]  mem_width_o,
  input  logic [31:0] mem_read_data_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [1:0]  resp_err_q, resp_err_d;
  logic [31:0] resp_addr_q, resp_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_read_valid_q, mem_read_valid_d;
  logic        mem_write_valid_q, mem_write_valid_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [1:0]  mem_width_q, mem_width_d;

  logic [31:0] ea_s;
  logic [1:0]  width_s;
  logic        illegal_s, misalign_s, accept_s, timeout_s;

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b010:  r = d;
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign ea_s       = req_base_i + req_offset_i;
  assign width_s    = req_funct3_i[1:0];
  assign illegal_s  = (width_s == 2'b11) || (req_is_store_i && req_funct3_i[2]);
  assign misalign_s = ((width_s == 2'b01) && ea_s[0]) ||
                      ((width_s == 2'b10) && (ea_s[1:0] != 2'b00));
  assign accept_s   = req_valid_i && req_ready_q;
  // A zero MEM_TIMEOUT disables the timeout entirely.
  assign timeout_s  = (MEM_TIMEOUT != 32'd0) && (cnt_q == MEM_TIMEOUT - 32'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      cnt_q             <= 32'd0;
      funct3_q          <= 3'd0;
      req_ready_q       <= 1'b1;
      resp_valid_q      <= 1'b0;
      resp_data_q       <= 32'd0;
      resp_rd_q         <= 5'd0;
      resp_err_q        <= 2'd0;
      resp_addr_q       <= 32'd0;
      mem_addr_q        <= 32'd0;
      mem_read_valid_q  <= 1'b0;
      mem_write_valid_q <= 1'b0;
      mem_write_data_q  <= 32'd0;
      mem_width_q       <= 2'd0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      funct3_q          <= funct3_d;
      req_ready_q       <= req_ready_d;
      resp_valid_q      <= resp_valid_d;
      resp_data_q       <= resp_data_d;
      resp_rd_q         <= resp_rd_d;
      resp_err_q        <= resp_err_d;
      resp_addr_q       <= resp_addr_d;
      mem_addr_q        <= mem_addr_d;
      mem_read_valid_q  <= mem_read_valid_d;
      mem_write_valid_q <= mem_write_valid_d;
      mem_write_data_q  <= mem_write_data_d;
      mem_width_q       <= mem_width_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (illegal_s || misalign_s || req_is_store_i) state_d = S_RESP;
          else                                           state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_ready_i || timeout_s) state_d = S_RESP;
        else                          state_d = S_WAIT;
      end
      S_RESP: begin
        if (resp_valid_q && resp_ready_i) state_d = S_IDLE;
        else                              state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stores enter RESP with resp_valid low; RESP raises it one edge later.
  always_comb begin
    cnt_d             = cnt_q;
    funct3_d          = funct3_q;
    req_ready_d       = req_ready_q;
    resp_valid_d      = resp_valid_q;
    resp_data_d       = resp_data_q;
    resp_rd_d         = resp_rd_q;
    resp_err_d        = resp_err_q;
    resp_addr_d       = resp_addr_q;
    mem_addr_d        = mem_addr_q;
    mem_read_valid_d  = 1'b0;
    mem_write_valid_d = 1'b0;
    mem_write_data_d  = mem_write_data_q;
    mem_width_d       = mem_width_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          req_ready_d = 1'b0;
          resp_addr_d = ea_s;
          resp_rd_d   = req_rd_i;
          resp_data_d = 32'd0;
          funct3_d    = req_funct3_i;
          if (illegal_s) begin
            resp_err_d   = 2'd2;
            resp_valid_d = 1'b1;
          end else if (misalign_s) begin
            resp_err_d   = 2'd1;
            resp_valid_d = 1'b1;
          end else begin
            resp_err_d   = 2'd0;
            resp_valid_d = 1'b0;
            mem_addr_d   = ea_s;
            mem_width_d  = width_s;
            if (req_is_store_i) begin
              mem_write_valid_d = 1'b1;
              mem_write_data_d  = req_store_data_i;
            end else begin
              mem_read_valid_d = 1'b1;
              cnt_d            = 32'd0;
            end
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 2'd0;
          resp_data_d  = extend_load(funct3_q, mem_read_data_i);
        end else if (timeout_s) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 2'd3;
          resp_data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RESP: begin
        if (resp_valid_q && resp_ready_i) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  assign req_ready_o       = req_ready_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_data_o       = resp_data_q;
  assign resp_rd_o         = resp_rd_q;
  assign resp_err_o        = resp_err_q;
  assign resp_addr_o       = resp_addr_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_read_valid_o  = mem_read_valid_q;
  assign mem_write_valid_o = mem_write_valid_q;
  assign mem_write_data_o  = mem_write_data_q;
  assign mem_width_o       = mem_width_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single accesses against a small byte RAM
// model, plus timeout/backpressure and asynchronous-reset-mid-wait sequences.
module tb_load_store_unit;

  localparam int unsigned TMO = 16;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_store_data;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data, resp_addr;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr, mem_write_data, ram_rdata;
  logic        mem_read_valid, mem_write_valid, mem_ready;
  logic [1:0]  mem_width;

  logic [7:0]  ram [0:1023];
  logic        ram_en, force_ready, ram_ready;
  bit          ram_loaded = 1'b0;
  int          n_vec, n_err;

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [1:0]  err;
    logic [31:0] data;
    logic [1:0]  strobe;  // 0 none, 1 read, 2 write
    logic [1:0]  width;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [21];
  vec_t tmo_vec;

  load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
    .req_funct3_i(req_funct3), .req_base_i(req_base), .req_offset_i(req_offset),
    .req_store_data_i(req_store_data), .req_rd_i(req_rd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_rd_o(resp_rd), .resp_err_o(resp_err), .resp_addr_o(resp_addr),
    .mem_addr_o(mem_addr), .mem_read_valid_o(mem_read_valid),
    .mem_write_valid_o(mem_write_valid), .mem_write_data_o(mem_write_data),
    .mem_width_o(mem_width), .mem_read_data_i(ram_rdata), .mem_ready_i(mem_ready)
  );

  assign mem_ready = ram_ready | force_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM answers a read strobe in the same cycle (ready with lane-selected data).
  always @(negedge clk) begin : ram_model
    logic [9:0] a;
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h004] = 8'h11; ram[10'h005] = 8'h22; ram[10'h006] = 8'h33; ram[10'h007] = 8'h44;
      ram[10'h100] = 8'h11; ram[10'h101] = 8'h80; ram[10'h102] = 8'h01; ram[10'h103] = 8'h80;
      ram[10'h104] = 8'hEF; ram[10'h105] = 8'hBE; ram[10'h106] = 8'hAD; ram[10'h107] = 8'hDE;
      ram_loaded = 1'b1;
    end
    a = mem_addr[9:0];
    if (mem_write_valid) begin
      ram[a] = mem_write_data[7:0];
      if (mem_width != 2'd0) ram[a + 10'd1] = mem_write_data[15:8];
      if (mem_width == 2'd2) begin
        ram[a + 10'd2] = mem_write_data[23:16];
        ram[a + 10'd3] = mem_write_data[31:24];
      end
    end
    if (ram_en && mem_read_valid) begin
      ram_ready = 1'b1;
      case (mem_width)
        2'd0:    ram_rdata = {24'd0, ram[a]};
        2'd1:    ram_rdata = {16'd0, ram[a + 10'd1], ram[a]};
        default: ram_rdata = {ram[a + 10'd3], ram[a + 10'd2], ram[a + 10'd1], ram[a]};
      endcase
    end else begin
      ram_ready = 1'b0;
      ram_rdata = 32'd0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                              input logic [31:0] off, input logic [31:0] sdata, input logic [4:0] rd,
                              input logic [1:0] err, input logic [31:0] data, input logic [1:0] strobe,
                              input logic [1:0] width, input logic [31:0] addr);
    vec_t v;
    v.st = st; v.f3 = f3; v.base = base; v.off = off; v.sdata = sdata; v.rd = rd;
    v.err = err; v.data = data; v.strobe = strobe; v.width = width; v.addr = addr;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".strobes"}, {30'd0, mem_read_valid, mem_write_valid}, 32'd0);
    chk({tag, ".resp_data"}, resp_data, 32'd0);
    chk({tag, ".resp_rd_err"}, {25'd0, resp_rd, resp_err}, 32'd0);
    chk({tag, ".resp_addr"}, resp_addr, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata_width"}, {30'd0, mem_width}, 32'd0);
    chk({tag, ".mem_wdata"}, mem_write_data, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (v.err == 2'd3) ? int'(TMO) + 1 : ((v.err != 2'd0) ? 1 : 2);
    @(negedge clk);
    chk({tag, ".ready_pre"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3; req_base = v.base;
    req_offset = v.off; req_store_data = v.sdata; req_rd = v.rd;
    @(negedge clk);
    // Scramble the request after acceptance; the response must not follow it.
    req_valid = 1'b0; req_is_store = ~v.st; req_funct3 = ~v.f3; req_base = ~v.base;
    req_offset = ~v.off; req_store_data = ~v.sdata; req_rd = ~v.rd;
    chk({tag, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
    chk({tag, ".rd_strobe"}, {31'd0, mem_read_valid}, {31'd0, v.strobe == 2'd1});
    chk({tag, ".wr_strobe"}, {31'd0, mem_write_valid}, {31'd0, v.strobe == 2'd2});
    if (v.strobe != 2'd0) begin
      chk({tag, ".mem_addr"}, mem_addr, v.addr);
      chk({tag, ".mem_width"}, {30'd0, mem_width}, {30'd0, v.width});
    end
    if (v.strobe == 2'd2) chk({tag, ".mem_wdata"}, mem_write_data, v.sdata);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) chk({tag, ".strobe_1cyc"}, {30'd0, mem_read_valid, mem_write_valid}, 32'd0);
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".resp_err"}, {30'd0, resp_err}, {30'd0, v.err});
    chk({tag, ".resp_data"}, resp_data, v.data);
    chk({tag, ".resp_rd"}, {27'd0, resp_rd}, {27'd0, v.rd});
    chk({tag, ".resp_addr"}, resp_addr, v.addr);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, ".hold_err"}, {30'd0, resp_err}, {30'd0, v.err});
      chk({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, ".resp_done"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_base = 32'd0; req_offset = 32'd0; req_store_data = 32'd0; req_rd = 5'd0;
    resp_ready = 1'b0; ram_en = 1'b1; force_ready = 1'b0; n_vec = 0; n_err = 0;

    //             st    f3      base           off            sdata          rd     err   data           strb  w     addr
    tbl[0]  = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0000_0004, 32'h0,         5'd5,  2'd0, 32'hDEAD_BEEF, 2'd1, 2'd2, 32'h0000_0104);
    tbl[1]  = mk(1'b0, 3'b000, 32'h0000_0100, 32'h0000_0001, 32'h0,         5'd6,  2'd0, 32'hFFFF_FF80, 2'd1, 2'd0, 32'h0000_0101);
    tbl[2]  = mk(1'b0, 3'b100, 32'h0000_0101, 32'h0000_0000, 32'h0,         5'd7,  2'd0, 32'h0000_0080, 2'd1, 2'd0, 32'h0000_0101);
    tbl[3]  = mk(1'b0, 3'b001, 32'h0000_00FF, 32'h0000_0003, 32'h0,         5'd8,  2'd0, 32'hFFFF_8001, 2'd1, 2'd1, 32'h0000_0102);
    tbl[4]  = mk(1'b0, 3'b101, 32'h0000_0102, 32'h0000_0000, 32'h0,         5'd9,  2'd0, 32'h0000_8001, 2'd1, 2'd1, 32'h0000_0102);
    tbl[5]  = mk(1'b1, 3'b010, 32'h0000_0200, 32'h0000_0000, 32'h1234_5678, 5'd10, 2'd0, 32'h0,         2'd2, 2'd2, 32'h0000_0200);
    tbl[6]  = mk(1'b0, 3'b010, 32'h0000_0210, 32'hFFFF_FFF0, 32'h0,         5'd11, 2'd0, 32'h1234_5678, 2'd1, 2'd2, 32'h0000_0200);
    tbl[7]  = mk(1'b1, 3'b001, 32'h0000_0200, 32'h0000_0001, 32'hCAFE_F00D, 5'd12, 2'd1, 32'h0,         2'd0, 2'd0, 32'h0000_0201);
    tbl[8]  = mk(1'b0, 3'b011, 32'h0000_0100, 32'h0000_0000, 32'h0,         5'd13, 2'd2, 32'h0,         2'd0, 2'd0, 32'h0000_0100);
    tbl[9]  = mk(1'b1, 3'b100, 32'h0000_0200, 32'h0000_0000, 32'h5555_5555, 5'd14, 2'd2, 32'h0,         2'd0, 2'd0, 32'h0000_0200);
    tbl[10] = mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0,         5'd15, 2'd0, 32'h4433_2211, 2'd1, 2'd2, 32'h0000_0004);
    tbl[11] = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0000_0002, 32'h0,         5'd16, 2'd1, 32'h0,         2'd0, 2'd0, 32'h0000_0102);
    tbl[12] = mk(1'b0, 3'b001, 32'h0000_0103, 32'h0000_0000, 32'h0,         5'd17, 2'd1, 32'h0,         2'd0, 2'd0, 32'h0000_0103);
    tbl[13] = mk(1'b0, 3'b111, 32'h0000_0100, 32'h0000_0001, 32'h0,         5'd18, 2'd2, 32'h0,         2'd0, 2'd0, 32'h0000_0101);
    tbl[14] = mk(1'b1, 3'b000, 32'h0000_0203, 32'h0000_0000, 32'hAABB_CCDD, 5'd19, 2'd0, 32'h0,         2'd2, 2'd0, 32'h0000_0203);
    tbl[15] = mk(1'b0, 3'b000, 32'h0000_0200, 32'h0000_0003, 32'h0,         5'd20, 2'd0, 32'hFFFF_FFDD, 2'd1, 2'd0, 32'h0000_0203);
    tbl[16] = mk(1'b1, 3'b001, 32'h0000_0206, 32'h0000_0000, 32'h0000_F00F, 5'd21, 2'd0, 32'h0,         2'd2, 2'd1, 32'h0000_0206);
    tbl[17] = mk(1'b0, 3'b001, 32'h0000_0206, 32'h0000_0000, 32'h0,         5'd22, 2'd0, 32'hFFFF_F00F, 2'd1, 2'd1, 32'h0000_0206);
    tbl[18] = mk(1'b0, 3'b010, 32'h0000_0204, 32'h0000_0000, 32'h0,         5'd23, 2'd0, 32'hF00F_0000, 2'd1, 2'd2, 32'h0000_0204);
    tbl[19] = mk(1'b0, 3'b100, 32'h0000_0207, 32'h0000_0000, 32'h0,         5'd24, 2'd0, 32'h0000_00F0, 2'd1, 2'd0, 32'h0000_0207);
    tbl[20] = mk(1'b1, 3'b110, 32'h0000_0201, 32'h0000_0000, 32'h7777_7777, 5'd26, 2'd2, 32'h0,         2'd0, 2'd0, 32'h0000_0201);
    tmo_vec = mk(1'b0, 3'b010, 32'h0000_0100, 32'h0000_0004, 32'h0,         5'd25, 2'd3, 32'h0,         2'd1, 2'd2, 32'h0000_0104);

    @(negedge clk);
    check_idle_outputs("reset");
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset.ready_after", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 21; i++) run_vec(tbl[i], 0, $sformatf("v%0d", i));

    // Timeout with the consumer stalling the response for five cycles.
    ram_en = 1'b0;
    run_vec(tmo_vec, 5, "timeout");
    ram_en = 1'b1;

    // Asynchronous reset while a load waits; a late mem_ready must be ignored.
    ram_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h0000_0100; req_offset = 32'h0000_0004; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwait.strobe", {31'd0, mem_read_valid}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rstwait.busy", {31'd0, req_ready}, 32'd0);
    #1 rst = 1'b1;
    #1 check_idle_outputs("rstwait");
    #1 rst = 1'b0;
    ram_en = 1'b1;
    force_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstwait.no_resp", {31'd0, resp_valid}, 32'd0);
      chk("rstwait.ready", {31'd0, req_ready}, 32'd1);
    end
    force_ready = 1'b0;
    run_vec(tbl[0], 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
